// File: rtl/mult_sequencer.sv
// rtl/mult_sequencer.sv - shift-add 32x32 unsigned multiply sequencer driving an external 64-bit adder
// Optional MULT_EARLY_TERM_EN: stop iterating once the remaining multiplier bits are all zero.
module mult_sequencer #(
  parameter logic [5:0] MULTU = 6'b011001,
  parameter logic [5:0] OUT   = 6'b111111,
  parameter logic [5:0] ADDU  = 6'b100001
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  Signal,
  input  logic [31:0] dataA,
  input  logic [31:0] dataB,
  output logic [5:0]  alu_ctl,
  output logic [63:0] add_a,
  output logic [63:0] add_b,
  input  logic [63:0] add_sum,
  output logic        busy,
  output logic        done,
  output logic [63:0] dataOut
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q;
  logic [63:0] mcand_q;
  logic [31:0] mplier_q;
  logic [63:0] product_q;
  logic [63:0] product_d;
  logic [5:0]  cnt_q;
  logic [63:0] dataout_q;
  logic        busy_q;
  logic        done_q;
  logic [5:0]  alu_ctl_q;
  logic        iter_stop;
  logic        last_iter;

  // The adder always sees product + shifted multiplicand; the LSB decides whether to keep the sum.
  assign product_d = mplier_q[0] ? add_sum : product_q;

`ifdef MULT_EARLY_TERM_EN
  assign iter_stop = (mplier_q == 32'd0);
`else
  assign iter_stop = 1'b0;
`endif
  assign last_iter = iter_stop || (cnt_q == 6'd31);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      mcand_q   <= 64'd0;
      mplier_q  <= 32'd0;
      product_q <= 64'd0;
      cnt_q     <= 6'd0;
      dataout_q <= 64'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      alu_ctl_q <= 6'd0;
    end else begin
      if ((Signal == OUT) && (state_q != ITER)) begin
        dataout_q <= product_q;
      end
      case (state_q)
        IDLE: begin
          if (Signal == MULTU) begin
            mcand_q   <= {32'd0, dataA};
            mplier_q  <= dataB;
            product_q <= 64'd0;
            cnt_q     <= 6'd0;
            state_q   <= ITER;
            busy_q    <= 1'b1;
            alu_ctl_q <= ADDU;
          end
        end
        ITER: begin
          if (!iter_stop) begin
            product_q <= product_d;
            mcand_q   <= mcand_q << 1;
            mplier_q  <= mplier_q >> 1;
            cnt_q     <= cnt_q + 6'd1;
          end
          if (last_iter) begin
            state_q   <= DONE;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            alu_ctl_q <= 6'd0;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q   <= IDLE;
          busy_q    <= 1'b0;
          done_q    <= 1'b0;
          alu_ctl_q <= 6'd0;
        end
      endcase
    end
  end

  assign alu_ctl = alu_ctl_q;
  assign add_a   = product_q;
  assign add_b   = mcand_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign dataOut = dataout_q;

endmodule

// File: tb/tb_mult_sequencer.sv
// tb/tb_mult_sequencer.sv - scoreboard bench for mult_sequencer with a behavioural multiply model
// Honours MULT_EARLY_TERM_EN when computing expected latency.
module tb_mult_sequencer;

  localparam logic [5:0] MULTU = 6'b011001;
  localparam logic [5:0] OUT   = 6'b111111;
  localparam logic [5:0] ADDU  = 6'b100001;
  localparam logic [5:0] NOP   = 6'b000000;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  Signal;
  logic [31:0] dataA;
  logic [31:0] dataB;
  logic [5:0]  alu_ctl;
  logic [63:0] add_a;
  logic [63:0] add_b;
  logic [63:0] add_sum;
  logic        busy;
  logic        done;
  logic [63:0] dataOut;

  mult_sequencer dut (
    .clk     (clk),
    .reset   (reset),
    .Signal  (Signal),
    .dataA   (dataA),
    .dataB   (dataB),
    .alu_ctl (alu_ctl),
    .add_a   (add_a),
    .add_b   (add_b),
    .add_sum (add_sum),
    .busy    (busy),
    .done    (done),
    .dataOut (dataOut)
  );

  // External chained ALU pair: plain 64-bit add, carry discarded.
  assign add_sum = add_a + add_b;

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int          exp_done_q[$];
  logic [63:0] exp_out_q[$];

  // Model: one operation accepted at edge op_e, done visible after edge op_e+op_l-1.
  bit          active = 1'b0;
  int          op_e = 0;
  int          op_l = 0;
  logic [63:0] op_prod = 64'd0;
  logic [63:0] m_prod = 64'd0;
  logic [63:0] m_dout = 64'd0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int lat_of(input logic [31:0] b);
    int msb = -1;
    for (int i = 0; i < 32; i++) if (b[i]) msb = i;
`ifdef MULT_EARLY_TERM_EN
    if (msb < 0) return 2;
    return (msb + 3 > 33) ? 33 : msb + 3;
`else
    return (msb < 0) ? 33 : 33;
`endif
  endfunction

  task automatic step(input logic [5:0] sig, input logic [31:0] a, input logic [31:0] b);
    int t;
    @(negedge clk);
    reset  = 1'b1;
    Signal = sig;
    dataA  = a;
    dataB  = b;
    t = cyc + 1;
    if (active && t >= op_e + op_l) m_prod = op_prod;
    if (active && t >= op_e + op_l + 1) active = 1'b0;
    if (sig == MULTU && !active) begin
      active  = 1'b1;
      op_e    = t;
      op_l    = lat_of(b);
      op_prod = {32'd0, a} * {32'd0, b};
      exp_done_q.push_back(t + op_l - 1);
    end
    if (sig == OUT) begin
      if (!active || t >= op_e + op_l) m_dout = m_prod;
      exp_out_q.push_back(m_dout);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset  = 1'b0;
    Signal = NOP;
    active = 1'b0;
    m_prod = 64'd0;
    m_dout = 64'd0;
    exp_done_q.delete();
    @(negedge clk);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_alu_ctl", {58'd0, alu_ctl}, 64'd0);
    check("rst_dataOut", dataOut, 64'd0);
  endtask

  task automatic drain();
    int n = 0;
    while (active && n < 80) begin
      step(NOP, 32'd0, 32'd0);
      n++;
    end
    if (active) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got active expected idle");
    end
  endtask

  task automatic mul_and_read(input logic [31:0] a, input logic [31:0] b);
    step(MULTU, a, b);
    drain();
    step(OUT, 32'd0, 32'd0);
    step(NOP, 32'd0, 32'd0);
  endtask

  // Monitor: pops expectations whenever the DUT shows done or an OUT edge occurred.
  always @(posedge clk) begin
    logic [5:0] s;
    logic       rs;
    s  = Signal;
    rs = reset;
    #1;
    cyc++;
    if (rs && s == OUT) begin
      if (exp_out_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dataOut_sb: got %h expected none queued", dataOut);
      end else begin
        check("dataOut", dataOut, exp_out_q.pop_front());
      end
    end
    if (exp_done_q.size() > 0 && exp_done_q[0] < cyc) begin
      checks++;
      errors++;
      $display("FAIL done_missed: got no pulse expected cycle %0d", exp_done_q.pop_front());
    end
    if (done) begin
      if (exp_done_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done_unexpected: got pulse at cycle %0d expected none", cyc);
      end else begin
        check("done_cycle", 64'(cyc), 64'(exp_done_q.pop_front()));
      end
    end
  end

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  sig;
    int          k;
    reset  = 1'b0;
    Signal = NOP;
    dataA  = 32'd0;
    dataB  = 32'd0;
    do_reset();

    // 3x5 with a look at the ITER outputs one cycle in
    step(MULTU, 32'd3, 32'd5);
    step(NOP, 32'd0, 32'd0);
    check("busy_iter", {63'd0, busy}, 64'd1);
    check("alu_ctl_iter", {58'd0, alu_ctl}, {58'd0, ADDU});
    drain();
    check("busy_idle", {63'd0, busy}, 64'd0);
    step(OUT, 32'd0, 32'd0);
    step(NOP, 32'd0, 32'd0);
    check("model_3x5", m_dout, 64'd15);

    mul_and_read(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("model_max", m_dout, 64'hFFFF_FFFE_0000_0001);

    // Second MULTU mid-operation must be ignored
    step(MULTU, 32'd3, 32'd5);
    for (int i = 0; i < 9; i++) step(NOP, 32'd0, 32'd0);
    step(MULTU, 32'd7, 32'd9);
    drain();
    step(OUT, 32'd0, 32'd0);
    step(NOP, 32'd0, 32'd0);

    // Abort by reset partway through, then restart right after release
    step(MULTU, 32'd3, 32'd5);
    for (int i = 0; i < 10; i++) step(NOP, 32'd0, 32'd0);
    do_reset();
    mul_and_read(32'd2, 32'd4);

    // OUT during ITER is ignored; OUT in the DONE cycle captures the product
    step(MULTU, 32'd6, 32'd7);
    step(NOP, 32'd0, 32'd0);
    if (active) step(OUT, 32'd0, 32'd0);
    k = 0;
    while (active && (cyc + 1) < op_e + op_l && k < 60) begin
      step(NOP, 32'd0, 32'd0);
      k++;
    end
    step(OUT, 32'd0, 32'd0);
    step(NOP, 32'd0, 32'd0);

    mul_and_read(32'd9, 32'd1);
    mul_and_read(32'd12345, 32'd0);

    for (int it = 0; it < 25; it++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = $urandom;
        1: b = 32'($urandom_range(0, 255));
        2: b = 32'd1 << $urandom_range(0, 31);
        default: b = 32'd0;
      endcase
      step(MULTU, a, b);
      k = $urandom_range(0, 40);
      for (int j = 0; j < k; j++) begin
        case ($urandom_range(0, 5))
          0: sig = OUT;
          1: sig = MULTU;
          2: sig = 6'($urandom_range(0, 63));
          default: sig = NOP;
        endcase
        step(sig, $urandom, $urandom);
      end
      drain();
      step(OUT, 32'd0, 32'd0);
    end

    for (int i = 0; i < 3; i++) step(NOP, 32'd0, 32'd0);
    k = 0;
    while ((exp_done_q.size() > 0 || exp_out_q.size() > 0) && k < 100) begin
      step(NOP, 32'd0, 32'd0);
      k++;
    end
    if (exp_done_q.size() > 0 || exp_out_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL queues_drained: got %0d/%0d pending expected 0/0", exp_done_q.size(), exp_out_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
